// File: rtl/pll_reset_sequencer.sv
// Qualifies the asynchronous PLL lock, sequences the synchronous core reset release
// and generates the 1-in-CE_DIV pixel clock-enable strobes once the core is running.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16,
  parameter int CE_DIV        = 8
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       soft_reset,
  output logic       core_reset_n,
  output logic       running,
  output logic       ce_pix,
  output logic       ce_pix_n,
  output logic [7:0] unlock_count,
  output logic [1:0] state
);

  localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
  localparam logic [1:0] ST_STABLE    = 2'd1;
  localparam logic [1:0] ST_HOLD      = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int DW = $clog2(CE_DIV);

  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST    = DW'(CE_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF    = DW'(CE_DIV / 2 - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   locked_s;
  logic [1:0]             state_r;
  logic [1:0]             state_next_s;
  logic [SW-1:0]          stable_cnt_r;
  logic [SW-1:0]          stable_next_s;
  logic [HW-1:0]          hold_cnt_r;
  logic [HW-1:0]          hold_next_s;
  logic [DW-1:0]          div_r;
  logic [DW-1:0]          div_next_s;
  logic [7:0]             unlock_r;
  logic                   unlock_inc_s;
  logic                   core_reset_n_r;
  logic                   running_r;

  assign locked_s = sync_r[SYNC_STAGES-1];

  // Lock synchronizer: pll_locked is asynchronous and is used nowhere else.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pll_locked};
    end
  end

  // Sequencer next-state; a lock loss always takes priority over soft_reset.
  always_comb begin
    state_next_s  = state_r;
    stable_next_s = '0;
    hold_next_s   = '0;
    unlock_inc_s  = 1'b0;
    case (state_r)
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_next_s = ST_STABLE;
        end else begin
          state_next_s = ST_WAIT_LOCK;
        end
      end
      ST_STABLE: begin
        if (!locked_s) begin
          state_next_s = ST_WAIT_LOCK;
        end else if (stable_cnt_r == STABLE_LAST) begin
          state_next_s = ST_HOLD;
        end else begin
          stable_next_s = stable_cnt_r + SW'(1);
        end
      end
      ST_HOLD: begin
        if (!locked_s) begin
          state_next_s = ST_WAIT_LOCK;
        end else if (soft_reset) begin
          hold_next_s = '0;
        end else if (hold_cnt_r == HOLD_LAST) begin
          state_next_s = ST_RUN;
        end else begin
          hold_next_s = hold_cnt_r + HW'(1);
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_next_s = ST_WAIT_LOCK;
          unlock_inc_s = 1'b1;
        end else if (soft_reset) begin
          state_next_s = ST_HOLD;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      default: begin
        state_next_s = ST_WAIT_LOCK;
      end
    endcase
  end

  // Pixel divider only runs across consecutive RUN cycles, so it is 0 on RUN entry.
  always_comb begin
    div_next_s = '0;
    if ((state_r == ST_RUN) && (state_next_s == ST_RUN)) begin
      if (div_r == DIV_LAST) begin
        div_next_s = '0;
      end else begin
        div_next_s = div_r + DW'(1);
      end
    end else begin
      div_next_s = '0;
    end
  end

  // Sequencer state, counters and registered reset/running outputs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= ST_WAIT_LOCK;
      stable_cnt_r   <= '0;
      hold_cnt_r     <= '0;
      div_r          <= '0;
      unlock_r       <= 8'd0;
      core_reset_n_r <= 1'b0;
      running_r      <= 1'b0;
    end else begin
      state_r        <= state_next_s;
      stable_cnt_r   <= stable_next_s;
      hold_cnt_r     <= hold_next_s;
      div_r          <= div_next_s;
      core_reset_n_r <= (state_next_s == ST_RUN);
      running_r      <= (state_next_s == ST_RUN);
      if (unlock_inc_s && (unlock_r != 8'hFF)) begin
        unlock_r <= unlock_r + 8'd1;
      end else begin
        unlock_r <= unlock_r;
      end
    end
  end

  assign core_reset_n = core_reset_n_r;
  assign running      = running_r;
  assign ce_pix       = (state_r == ST_RUN) && (div_r == DIV_LAST);
  assign ce_pix_n     = (state_r == ST_RUN) && (div_r == DIV_HALF);
  assign unlock_count = unlock_r;
  assign state        = state_r;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed scenarios plus randomized lock/soft-reset
// traffic, all checked against a countdown/age-based behavioural model.
module tb_pll_reset_sequencer;

  localparam int SYNC_STAGES   = 2;
  localparam int STABLE_CYCLES = 4;
  localparam int HOLD_CYCLES   = 2;
  localparam int CE_DIV        = 8;

  logic       clk_sys    = 1'b0;
  logic       reset_n    = 1'b0;
  logic       pll_locked = 1'b0;
  logic       soft_reset = 1'b0;
  logic       core_reset_n;
  logic       running;
  logic       ce_pix;
  logic       ce_pix_n;
  logic [7:0] unlock_count;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  // Model: delay line for lock, phase, cycles remaining in phase, cycles spent in RUN.
  bit m_hist[$];
  int m_phase;
  int m_remaining;
  int m_age;
  int m_count;

  pll_reset_sequencer #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES),
    .HOLD_CYCLES  (HOLD_CYCLES),
    .CE_DIV       (CE_DIV)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .pll_locked  (pll_locked),
    .soft_reset  (soft_reset),
    .core_reset_n(core_reset_n),
    .running     (running),
    .ce_pix      (ce_pix),
    .ce_pix_n    (ce_pix_n),
    .unlock_count(unlock_count),
    .state       (state)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [13:0] obs_vec();
    return {core_reset_n, running, ce_pix, ce_pix_n, state, unlock_count};
  endfunction

  function automatic logic [13:0] exp_vec();
    logic run;
    int   ph;
    run = (m_phase == 3);
    ph  = m_age % CE_DIV;
    return {run, run, run && (ph == CE_DIV - 1), run && (ph == CE_DIV / 2 - 1),
            2'(m_phase), 8'(m_count)};
  endfunction

  task automatic model_reset();
    m_hist = {};
    for (int i = 0; i < SYNC_STAGES; i++) m_hist.push_back(1'b0);
    m_phase     = 0;
    m_remaining = 0;
    m_age       = 0;
    m_count     = 0;
  endtask

  task automatic model_step();
    bit ls;
    if (!reset_n) begin
      model_reset();
      return;
    end
    ls = m_hist[0];
    void'(m_hist.pop_front());
    m_hist.push_back(pll_locked);
    case (m_phase)
      0: if (ls) begin m_phase = 1; m_remaining = STABLE_CYCLES - 1; end
      1: begin
        if (!ls) m_phase = 0;
        else if (m_remaining == 0) begin m_phase = 2; m_remaining = HOLD_CYCLES - 1; end
        else m_remaining--;
      end
      2: begin
        if (!ls) m_phase = 0;
        else if (soft_reset) m_remaining = HOLD_CYCLES - 1;
        else if (m_remaining == 0) begin m_phase = 3; m_age = 0; end
        else m_remaining--;
      end
      default: begin
        if (!ls) begin
          m_phase = 0;
          if (m_count < 255) m_count++;
        end else if (soft_reset) begin
          m_phase = 2;
          m_remaining = HOLD_CYCLES - 1;
        end else m_age++;
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk_sys);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    soft_reset = 1'b0;
    model_reset();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic wait_level(input logic lvl);
    int n = 0;
    while (running !== lvl && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (running !== lvl) begin
      bad++;
      $display("FAIL wait_running: running=%b after %0d cycles, required %b", running, n, lvl);
    end
  endtask

  task automatic test_reset();
    logic [1:0] exp_state;
    logic       exp_rel, exp_ce, exp_cen;
    model_reset();
    #2;
    total++;
    if (obs_vec() !== 14'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h required 0000", obs_vec());
    end
    tick();
    tick();
    reset_n = 1'b1;
    total++;
    if (obs_vec() !== 14'd0) begin
      bad++;
      $display("FAIL reset_release_outputs: got %h required 0000", obs_vec());
    end
    pll_locked = 1'b1;
    for (int e = 1; e <= 26; e++) begin
      tick();
      exp_state = (e < 3) ? 2'd0 : (e < 7) ? 2'd1 : (e < 9) ? 2'd2 : 2'd3;
      exp_rel   = (e >= 9);
      exp_ce    = (e >= 9) && ((e - 9) % 8 == 7);
      exp_cen   = (e >= 9) && ((e - 9) % 8 == 3);
      total++;
      if (state !== exp_state) begin
        bad++;
        $display("FAIL seq_state E%0d: got %0d required %0d", e, state, exp_state);
      end
      total++;
      if ({core_reset_n, running} !== {exp_rel, exp_rel}) begin
        bad++;
        $display("FAIL seq_release E%0d: got %b%b required %b%b", e, core_reset_n, running, exp_rel, exp_rel);
      end
      total++;
      if ({ce_pix, ce_pix_n} !== {exp_ce, exp_cen}) begin
        bad++;
        $display("FAIL seq_strobes E%0d: got %b%b required %b%b", e, ce_pix, ce_pix_n, exp_ce, exp_cen);
      end
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL seq_model E%0d: got %h required %h", e, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_glitch_stable();
    do_reset();
    pll_locked = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (state !== 2'd1) begin
      bad++;
      $display("FAIL glitch_pre_state: got %0d required 1", state);
    end
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    for (int r = 1; r <= 10; r++) begin
      tick();
      if (r == 2) begin
        total++;
        if (state !== 2'd0) begin
          bad++;
          $display("FAIL glitch_restart R%0d: state got %0d required 0", r, state);
        end
      end
      total++;
      if (core_reset_n !== (r >= 9)) begin
        bad++;
        $display("FAIL glitch_release R%0d: got %b required %b", r, core_reset_n, (r >= 9));
      end
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL glitch_model R%0d: got %h required %h", r, obs_vec(), exp_vec());
      end
    end
    total++;
    if (unlock_count !== 8'd0) begin
      bad++;
      $display("FAIL glitch_count: got %0d required 0", unlock_count);
    end
  endtask

  task automatic test_lock_loss_run();
    do_reset();
    pll_locked = 1'b1;
    wait_level(1'b1);
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 3; k++) tick();
      pll_locked = 1'b0;
      for (int d = 1; d <= 3; d++) begin
        tick();
        total++;
        if (core_reset_n !== (d < 3)) begin
          bad++;
          $display("FAIL loss_release loss%0d D%0d: got %b required %b", i, d, core_reset_n, (d < 3));
        end
      end
      for (int k = 0; k < 10; k++) begin
        total++;
        if ({ce_pix, ce_pix_n, state} !== 4'b0000) begin
          bad++;
          $display("FAIL loss_strobes loss%0d: got %b%b st=%0d required 00 st=0", i, ce_pix, ce_pix_n, state);
        end
        tick();
      end
      pll_locked = 1'b1;
      wait_level(1'b1);
    end
    total++;
    if (unlock_count !== 8'd3) begin
      bad++;
      $display("FAIL loss_count3: got %0d required 3", unlock_count);
    end
    for (int i = 3; i < 300; i++) begin
      pll_locked = 1'b0;
      wait_level(1'b0);
      pll_locked = 1'b1;
      wait_level(1'b1);
    end
    total++;
    if (unlock_count !== 8'd255) begin
      bad++;
      $display("FAIL loss_saturate: got %0d required 255", unlock_count);
    end
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL loss_model: got %h required %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_soft_reset();
    do_reset();
    pll_locked = 1'b1;
    wait_level(1'b1);
    for (int k = 0; k < 5; k++) tick();
    soft_reset = 1'b1;
    for (int s = 0; s <= 17; s++) begin
      tick();
      soft_reset = 1'b0;
      total++;
      if (core_reset_n !== (s >= 2)) begin
        bad++;
        $display("FAIL soft_release S+%0d: got %b required %b", s, core_reset_n, (s >= 2));
      end
      total++;
      if (ce_pix !== (s == 9 || s == 17)) begin
        bad++;
        $display("FAIL soft_ce_pix S+%0d: got %b required %b", s, ce_pix, (s == 9 || s == 17));
      end
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL soft_model S+%0d: got %h required %h", s, obs_vec(), exp_vec());
      end
    end
    // soft_reset while waiting for lock must not disturb the normal sequence
    do_reset();
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    total++;
    if ({state, core_reset_n} !== 3'b000) begin
      bad++;
      $display("FAIL soft_wait: got st=%0d rst=%b required st=0 rst=0", state, core_reset_n);
    end
    pll_locked = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      tick();
      total++;
      if (core_reset_n !== (e == 9)) begin
        bad++;
        $display("FAIL soft_wait_seq E%0d: got %b required %b", e, core_reset_n, (e == 9));
      end
    end
    tick();
    tick();
    pll_locked = 1'b0;
    tick();
    tick();
    total++;
    if (state !== 2'd3) begin
      bad++;
      $display("FAIL soft_loss_pre: state got %0d required 3", state);
    end
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    total++;
    if ({state, unlock_count} !== {2'd0, 8'd1}) begin
      bad++;
      $display("FAIL soft_loss_same: got st=%0d cnt=%0d required st=0 cnt=1", state, unlock_count);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    pll_locked = 1'b1;
    wait_level(1'b1);
    for (int k = 0; k < 4; k++) tick();
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    total++;
    if (obs_vec() !== 14'd0) begin
      bad++;
      $display("FAIL async_reset: got %h required 0000", obs_vec());
    end
    tick();
    reset_n = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      total++;
      if ({state, core_reset_n} !== {((e < 3) ? 2'd0 : (e < 7) ? 2'd1 : (e < 9) ? 2'd2 : 2'd3), (e >= 9)}) begin
        bad++;
        $display("FAIL async_seq E%0d: got st=%0d rst=%b required rst=%b", e, state, core_reset_n, (e >= 9));
      end
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL async_model E%0d: got %h required %h", e, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 4) pll_locked = ~pll_locked;
      soft_reset = ($urandom_range(0, 99) < 3);
      tick();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL random_model cyc%0d: got %h required %h", i, obs_vec(), exp_vec());
      end
      total++;
      if (ce_pix && ce_pix_n) begin
        bad++;
        $display("FAIL random_overlap cyc%0d: got 11 required not both", i);
      end
    end
    soft_reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_glitch_stable();
    test_lock_loss_run();
    test_soft_reset();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
